id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32 core, directly upstream of the forwarding unit.
- Captures decoded operands and control from ID and presents the ID_EX_* register fields that the forwarding unit and EX stage consume.
- Contains the load-use hazard detector: stalls PC and IF/ID, and inserts a bubble into EX.
- Squashes the instruction in ID on an EX-resolved control transfer.
- Keeps a saturating bubble-cycle performance counter.

Parameters:
- BIT_WIDTH, 5, register-index width.
- DATA_WIDTH, 32, datapath width.
- CNT_WIDTH, 16, width of the bubble counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID holds a real instruction.
- id_pc  input  DATA_WIDTH  PC of the ID instruction.
- id_rs1_data  input  DATA_WIDTH  register-file read port 1.
- id_rs2_data  input  DATA_WIDTH  register-file read port 2.
- id_imm  input  DATA_WIDTH  sign-extended immediate.
- id_rs1  input  BIT_WIDTH  source index 1.
- id_rs2  input  BIT_WIDTH  source index 2.
- id_rd  input  BIT_WIDTH  destination index.
- id_uses_rs1  input  1  instruction reads rs1.
- id_uses_rs2  input  1  instruction reads rs2.
- id_reg_write  input  1  decoded control signal.
- id_mem_read  input  1  decoded control signal.
- id_mem_write  input  1  decoded control signal.
- id_mem_to_reg  input  1  decoded control signal.
- id_alu_src  input  1  decoded control signal.
- id_branch  input  1  decoded control signal.
- id_jump  input  1  decoded control signal.
- id_alu_op  input  4  ALU operation select.
- ex_flush  input  1  taken branch/jump resolved in EX this cycle.
- stall  output  1  hold PC and IF/ID (combinational).
- ID_EX_valid  output  1  registered valid.
- ID_EX_PC  output  DATA_WIDTH  registered PC.
- ID_EX_A  output  DATA_WIDTH  registered rs1 data.
- ID_EX_B  output  DATA_WIDTH  registered rs2 data.
- ID_EX_Imm  output  DATA_WIDTH  registered immediate.
- ID_EX_Rs  output  BIT_WIDTH  registered rs1 index (to forwarding unit).
- ID_EX_Rt  output  BIT_WIDTH  registered rs2 index (to forwarding unit).
- ID_EX_Rd  output  BIT_WIDTH  registered rd index.
- ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc, ID_EX_Branch, ID_EX_Jump  output  1 each  registered controls.
- ID_EX_ALUOp  output  4  registered ALU operation select.
- bubble_count  output  CNT_WIDTH  bubbles inserted since reset.

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0, including bubble_count. stall is therefore 0 during reset. On release, resumes on the next rising edge.
- Hazard:
  - load_use = ID_EX_valid & ID_EX_MemRead & (ID_EX_Rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ID_EX_Rd) | (id_uses_rs2 & id_rs2 == ID_EX_Rd)).
  - stall = load_use & ~ex_flush. Purely combinational, no register in the path.
- Per rising edge, priority order:
  1. ex_flush=1: load a bubble.
  2. else load_use=1: load a bubble.
  3. else capture all id_* fields; ID_EX_valid <= id_valid.
- Bubble definition:
  - ID_EX_valid and all seven 1-bit controls = 0.
  - ID_EX_ALUOp = 0.
  - ID_EX_Rs/Rt/Rd = 0, so the forwarding unit never matches.
  - Data fields (PC, A, B, Imm) = 0.
- Invalid capture: id_valid=0 without flush or stall captures fields normally, but forces every control bit to 0. Indices are still captured.
- Load-use timing:
  - Exactly one bubble per load-use.
  - In the next cycle ID_EX_MemRead=0 (bubble), so stall drops. The held ID instruction then issues and receives the load result via MEM/WB forwarding.
- Flush with load-use in the same cycle: flush wins; stall=0, because the ID instruction is squashed and IF/ID must advance to the target.
- x0 rule: a load with rd=0 never causes a stall.
- bubble_count:
  - Increments by 1 on each edge where load_use & ~ex_flush.
  - Flush bubbles are not counted.
  - Saturates at all-ones, with no wrap.
- Latency: one cycle from id_* to ID_EX_*.
- No X propagation: unused inputs do not alter controls of a bubble.

Test Plan:
- Reset: assert rst_n=0 mid-run with ID_EX_MemRead=1 -> all outputs 0 immediately (asynchronous), stall=0, bubble_count=0.
- Pass-through: id_valid=1, add x3,x1,x2, reg_write=1 -> next edge ID_EX_Rs=1, ID_EX_Rt=2, ID_EX_Rd=3, ID_EX_RegWrite=1, stall=0 throughout.
- Load-use: lw x5 then add x6,x5,x7 (uses_rs1=1) -> stall=1 for exactly one cycle. Bubble cycle: ID_EX_valid=0, Rd=0. Next edge: add captured with Rs=5. bubble_count=1.
- rs2-only and x0: lw x0 followed by add x1,x0,x0 -> no stall. Then lw x4 followed by sw with uses_rs2=1, rs2=4 -> one stall.
- Flush priority: load-use condition and ex_flush=1 in the same cycle -> stall=0, bubble loaded, bubble_count unchanged.
- Saturation: CNT_WIDTH=2, five consecutive load-use pairs -> bubble_count 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush squash and saturating bubble counter
module id_ex_stage #(
   parameter int BIT_WIDTH  = 5,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [DATA_WIDTH-1:0] id_pc,
   input  logic [DATA_WIDTH-1:0] id_rs1_data,
   input  logic [DATA_WIDTH-1:0] id_rs2_data,
   input  logic [DATA_WIDTH-1:0] id_imm,
   input  logic [BIT_WIDTH-1:0]  id_rs1,
   input  logic [BIT_WIDTH-1:0]  id_rs2,
   input  logic [BIT_WIDTH-1:0]  id_rd,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  id_mem_to_reg,
   input  logic                  id_alu_src,
   input  logic                  id_branch,
   input  logic                  id_jump,
   input  logic [3:0]            id_alu_op,
   input  logic                  ex_flush,
   output logic                  stall,
   output logic                  ID_EX_valid,
   output logic [DATA_WIDTH-1:0] ID_EX_PC,
   output logic [DATA_WIDTH-1:0] ID_EX_A,
   output logic [DATA_WIDTH-1:0] ID_EX_B,
   output logic [DATA_WIDTH-1:0] ID_EX_Imm,
   output logic [BIT_WIDTH-1:0]  ID_EX_Rs,
   output logic [BIT_WIDTH-1:0]  ID_EX_Rt,
   output logic [BIT_WIDTH-1:0]  ID_EX_Rd,
   output logic                  ID_EX_RegWrite,
   output logic                  ID_EX_MemRead,
   output logic                  ID_EX_MemWrite,
   output logic                  ID_EX_MemToReg,
   output logic                  ID_EX_ALUSrc,
   output logic                  ID_EX_Branch,
   output logic                  ID_EX_Jump,
   output logic [3:0]            ID_EX_ALUOp,
   output logic [CNT_WIDTH-1:0]  bubble_count
);
   logic loadUse, bubble, ctlEn;
   assign loadUse = ID_EX_valid & ID_EX_MemRead & (ID_EX_Rd != '0) & id_valid &
                    ((id_uses_rs1 & (id_rs1 == ID_EX_Rd)) | (id_uses_rs2 & (id_rs2 == ID_EX_Rd)));
   assign stall   = loadUse & ~ex_flush;
   assign bubble  = ex_flush | loadUse;
   assign ctlEn   = id_valid & ~bubble;
   // pipeline register: bubble clears everything, otherwise capture with controls gated by valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ID_EX_valid    <= 1'b0;
         ID_EX_PC       <= '0;
         ID_EX_A        <= '0;
         ID_EX_B        <= '0;
         ID_EX_Imm      <= '0;
         ID_EX_Rs       <= '0;
         ID_EX_Rt       <= '0;
         ID_EX_Rd       <= '0;
         ID_EX_RegWrite <= 1'b0;
         ID_EX_MemRead  <= 1'b0;
         ID_EX_MemWrite <= 1'b0;
         ID_EX_MemToReg <= 1'b0;
         ID_EX_ALUSrc   <= 1'b0;
         ID_EX_Branch   <= 1'b0;
         ID_EX_Jump     <= 1'b0;
         ID_EX_ALUOp    <= '0;
      end else begin
         ID_EX_valid    <= ctlEn;
         ID_EX_PC       <= bubble ? '0 : id_pc;
         ID_EX_A        <= bubble ? '0 : id_rs1_data;
         ID_EX_B        <= bubble ? '0 : id_rs2_data;
         ID_EX_Imm      <= bubble ? '0 : id_imm;
         ID_EX_Rs       <= bubble ? '0 : id_rs1;
         ID_EX_Rt       <= bubble ? '0 : id_rs2;
         ID_EX_Rd       <= bubble ? '0 : id_rd;
         ID_EX_RegWrite <= ctlEn & id_reg_write;
         ID_EX_MemRead  <= ctlEn & id_mem_read;
         ID_EX_MemWrite <= ctlEn & id_mem_write;
         ID_EX_MemToReg <= ctlEn & id_mem_to_reg;
         ID_EX_ALUSrc   <= ctlEn & id_alu_src;
         ID_EX_Branch   <= ctlEn & id_branch;
         ID_EX_Jump     <= ctlEn & id_jump;
         ID_EX_ALUOp    <= ctlEn ? id_alu_op : 4'd0;
      end
   end
   // counts load-use bubbles only; flush bubbles are not hazards
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bubble_count <= '0;
      else if (stall && bubble_count != '1) bubble_count <= bubble_count + 1'b1;
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed-vector check of hazard, flush, capture, reset and counter saturation
module tb_id_ex_stage;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        id_valid, id_uses_rs1, id_uses_rs2, ex_flush;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch, id_jump;
   logic [3:0]  id_alu_op;
   logic        stall, ID_EX_valid, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg;
   logic        ID_EX_ALUSrc, ID_EX_Branch, ID_EX_Jump;
   logic [31:0] ID_EX_PC, ID_EX_A, ID_EX_B, ID_EX_Imm;
   logic [4:0]  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
   logic [3:0]  ID_EX_ALUOp;
   logic [15:0] bubble_count;
   logic        smStall, smValid, smRegWrite, smMemRead, smMemWrite, smMemToReg, smALUSrc, smBranch, smJump;
   logic [31:0] smPC, smA, smB, smImm;
   logic [4:0]  smRs, smRt, smRd;
   logic [3:0]  smALUOp;
   logic [1:0]  smCount;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
      .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
      .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump), .id_alu_op(id_alu_op),
      .ex_flush(ex_flush), .stall(stall), .ID_EX_valid(ID_EX_valid), .ID_EX_PC(ID_EX_PC),
      .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B), .ID_EX_Imm(ID_EX_Imm), .ID_EX_Rs(ID_EX_Rs),
      .ID_EX_Rt(ID_EX_Rt), .ID_EX_Rd(ID_EX_Rd), .ID_EX_RegWrite(ID_EX_RegWrite),
      .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemToReg(ID_EX_MemToReg),
      .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_Branch(ID_EX_Branch), .ID_EX_Jump(ID_EX_Jump),
      .ID_EX_ALUOp(ID_EX_ALUOp), .bubble_count(bubble_count)
   );

   id_ex_stage #(.CNT_WIDTH(2)) dutSmall (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
      .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
      .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump), .id_alu_op(id_alu_op),
      .ex_flush(ex_flush), .stall(smStall), .ID_EX_valid(smValid), .ID_EX_PC(smPC),
      .ID_EX_A(smA), .ID_EX_B(smB), .ID_EX_Imm(smImm), .ID_EX_Rs(smRs),
      .ID_EX_Rt(smRt), .ID_EX_Rd(smRd), .ID_EX_RegWrite(smRegWrite),
      .ID_EX_MemRead(smMemRead), .ID_EX_MemWrite(smMemWrite), .ID_EX_MemToReg(smMemToReg),
      .ID_EX_ALUSrc(smALUSrc), .ID_EX_Branch(smBranch), .ID_EX_Jump(smJump),
      .ID_EX_ALUOp(smALUOp), .bubble_count(smCount)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic rw, input logic mr, input logic mw);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_uses_rs1 = u1; id_uses_rs2 = u2;
      id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = mr;
      id_alu_src = mr | mw; id_branch = 1'b0; id_jump = 1'b0; id_alu_op = 4'h3;
      id_pc = 32'h100 + 32'(rd); id_rs1_data = 32'hA000_0000 | 32'(rs1);
      id_rs2_data = 32'hB000_0000 | 32'(rs2); id_imm = 32'(rd) * 4;
   endtask

   task automatic step;
      @(posedge clk); #1;
   endtask

   initial begin
      ex_flush = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(ID_EX_valid), 32'd0);
      check("rst_count", 32'(bubble_count), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      // pass-through: add x3,x1,x2
      drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      #1 check("pass_stall_pre", 32'(stall), 32'd0);
      step;
      check("pass_rs", 32'(ID_EX_Rs), 32'd1);
      check("pass_rt", 32'(ID_EX_Rt), 32'd2);
      check("pass_rd", 32'(ID_EX_Rd), 32'd3);
      check("pass_rw", 32'(ID_EX_RegWrite), 32'd1);
      check("pass_valid", 32'(ID_EX_valid), 32'd1);
      check("pass_a", ID_EX_A, 32'hA000_0001);
      check("pass_pc", ID_EX_PC, 32'h103);
      check("pass_aluop", 32'(ID_EX_ALUOp), 32'h3);
      check("pass_stall_post", 32'(stall), 32'd0);
      // load-use on rs1: lw x5 ; add x6,x5,x7
      drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step;
      check("lw_memread", 32'(ID_EX_MemRead), 32'd1);
      drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      #1 check("lu_stall", 32'(stall), 32'd1);
      step;
      check("lu_bub_valid", 32'(ID_EX_valid), 32'd0);
      check("lu_bub_rd", 32'(ID_EX_Rd), 32'd0);
      check("lu_bub_rw", 32'(ID_EX_RegWrite), 32'd0);
      check("lu_bub_a", ID_EX_A, 32'd0);
      check("lu_count", 32'(bubble_count), 32'd1);
      check("lu_stall_drop", 32'(stall), 32'd0);
      step;
      check("lu_issue_rs", 32'(ID_EX_Rs), 32'd5);
      check("lu_issue_rd", 32'(ID_EX_Rd), 32'd6);
      check("lu_issue_valid", 32'(ID_EX_valid), 32'd1);
      check("lu_count_hold", 32'(bubble_count), 32'd1);
      // x0 rule: lw x0 ; add x1,x0,x0
      drive(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step;
      drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      #1 check("x0_stall", 32'(stall), 32'd0);
      step;
      check("x0_rd", 32'(ID_EX_Rd), 32'd1);
      check("x0_count", 32'(bubble_count), 32'd1);
      // rs2-only hazard: lw x4 ; sw x4,0(x9)
      drive(1'b1, 5'd2, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step;
      drive(1'b1, 5'd9, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      #1 check("rs2_stall", 32'(stall), 32'd1);
      step;
      check("rs2_bub_valid", 32'(ID_EX_valid), 32'd0);
      check("rs2_bub_mw", 32'(ID_EX_MemWrite), 32'd0);
      check("rs2_count", 32'(bubble_count), 32'd2);
      step;
      check("rs2_issue_mw", 32'(ID_EX_MemWrite), 32'd1);
      check("rs2_issue_rt", 32'(ID_EX_Rt), 32'd4);
      // flush wins over load-use
      drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step;
      drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      ex_flush = 1'b1;
      #1 check("fl_stall", 32'(stall), 32'd0);
      step;
      ex_flush = 1'b0;
      check("fl_valid", 32'(ID_EX_valid), 32'd0);
      check("fl_rd", 32'(ID_EX_Rd), 32'd0);
      check("fl_rs", 32'(ID_EX_Rs), 32'd0);
      check("fl_count", 32'(bubble_count), 32'd2);
      // flush of a plain instruction also bubbles
      drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      ex_flush = 1'b1;
      step;
      ex_flush = 1'b0;
      check("fl2_rw", 32'(ID_EX_RegWrite), 32'd0);
      check("fl2_pc", ID_EX_PC, 32'd0);
      // invalid capture keeps indices, clears controls
      drive(1'b0, 5'd8, 5'd9, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      step;
      check("inv_rd", 32'(ID_EX_Rd), 32'd7);
      check("inv_rw", 32'(ID_EX_RegWrite), 32'd0);
      check("inv_mr", 32'(ID_EX_MemRead), 32'd0);
      check("inv_aluop", 32'(ID_EX_ALUOp), 32'd0);
      check("inv_valid", 32'(ID_EX_valid), 32'd0);
      // asynchronous reset mid-cycle with a load in EX
      drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step;
      check("pre_rst_mr", 32'(ID_EX_MemRead), 32'd1);
      drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("arst_mr", 32'(ID_EX_MemRead), 32'd0);
      check("arst_valid", 32'(ID_EX_valid), 32'd0);
      check("arst_rd", 32'(ID_EX_Rd), 32'd0);
      check("arst_stall", 32'(stall), 32'd0);
      check("arst_count", 32'(bubble_count), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      // saturation on the 2-bit counter instance
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
         step;
         drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
         step;
         check($sformatf("sat_small_%0d", i), 32'(smCount), (i < 3) ? 32'(i) : 32'd3);
         check($sformatf("sat_big_%0d", i), 32'(bubble_count), 32'(i));
         step;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
